i2c_master_writer: RTL and testbench

- Parametrised I2C write master, successor to the fixed 3-byte codec configuration interface.
- Generates START, NUM_BYTES MSB-first bytes, a real sampled ACK per byte, and STOP.
- Open-drain SDA and a configurable SCL rate from an internal divider; on NACK, retries automatically.
- Sits between the codec-config sequencer (drives START/DATA) and the codec I2C pins.

---
 rtl/i2c_pkg.sv | 42 ++++
 rtl/i2c_quarter_tick.sv | 33 +++
 rtl/i2c_master_writer.sv | 197 +++++++++++++++++++
 tb/tb_i2c_master_writer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | i2c_pkg: shared states, phase constants and bus-drive decoding  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    STA  = 3'd1,
    BIT  = 3'd2,
    ACK  = 3'd3,
    STP  = 3'd4,
    FIN  = 3'd5
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int STA_Q = 2;
  localparam int BIT_Q = 4;
  localparam int STP_Q = 3;

  // Returns {scl, sda_low} for a given state/quarter; sda_low=1 pulls SDA down.
  function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] q,
                                           input logic bit_val);
    logic [1:0] d;
    d = 2'b10;
    case (st)
      STA:     d = {1'b1, q == Q1};
      BIT:     d = {(q == Q1) || (q == Q2), ~bit_val};
      ACK:     d = {(q == Q1) || (q == Q2), 1'b0};
      STP:     d = {q != Q0, q != Q2};
      default: d = 2'b10;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_quarter_tick.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | i2c_quarter_tick: SCL quarter-period divider, cleared when EN=0 |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module i2c_quarter_tick #(
  parameter int CLK_DIV = 125
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  output logic TICK
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RESET || !EN) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign TICK = EN && (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/i2c_master_writer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | i2c_master_writer: multi-byte I2C write master with NACK retry  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module i2c_master_writer
  import i2c_pkg::*;
#(
  parameter int NUM_BYTES = 3,
  parameter int CLK_DIV   = 125,
  parameter int MAX_RETRY = 2
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               START,
  input  logic [8*NUM_BYTES-1:0]             DATA,
  output logic                               BUSY,
  output logic                               DONE,
  output logic                               NACK,
  output logic [$clog2(NUM_BYTES):0]         NACK_BYTE,
  output logic [$clog2(MAX_RETRY+1):0]       RETRIES,
  output logic                               I2C_SCLK,
  inout  wire                                I2C_SDAT
);

  localparam int DW = 8 * NUM_BYTES;
  localparam int BW = $clog2(NUM_BYTES) + 1;
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_t          state, state_n;
  logic [1:0]      q, q_n;
  logic [2:0]      bit_idx, bit_n;
  logic [BW-1:0]   byte_idx, byte_n;
  logic [DW-1:0]   data_q, data_n;
  logic            nsmp, nsmp_n;
  logic            failed, failed_n;
  logic            nack_q, nack_n;
  logic [BW-1:0]   nbyte_q, nbyte_n;
  logic [RW-1:0]   retries_q, retries_n;
  logic            scl_q, scl_n;
  logic            sda_low_q, sda_low_n;
  logic [DW-1:0]   shifted;
  logic [7:0]      cur_byte;
  logic            tick;
  logic            div_en;

  assign div_en = (state == STA) || (state == BIT) || (state == ACK) || (state == STP);

  i2c_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_qtick (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (div_en),
    .TICK  (tick)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      q         <= Q0;
      bit_idx   <= 3'd7;
      byte_idx  <= '0;
      data_q    <= '0;
      nsmp      <= 1'b0;
      failed    <= 1'b0;
      nack_q    <= 1'b0;
      nbyte_q   <= '0;
      retries_q <= '0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
    end else begin
      state     <= state_n;
      q         <= q_n;
      bit_idx   <= bit_n;
      byte_idx  <= byte_n;
      data_q    <= data_n;
      nsmp      <= nsmp_n;
      failed    <= failed_n;
      nack_q    <= nack_n;
      nbyte_q   <= nbyte_n;
      retries_q <= retries_n;
      scl_q     <= scl_n;
      sda_low_q <= sda_low_n;
    end
  end

  always_comb begin
    state_n   = state;
    q_n       = q;
    bit_n     = bit_idx;
    byte_n    = byte_idx;
    data_n    = data_q;
    nsmp_n    = nsmp;
    failed_n  = failed;
    nack_n    = nack_q;
    nbyte_n   = nbyte_q;
    retries_n = retries_q;

    case (state)
      IDLE: begin
        if (START) begin
          state_n   = STA;
          q_n       = Q0;
          bit_n     = 3'd7;
          byte_n    = '0;
          data_n    = DATA;
          failed_n  = 1'b0;
          nack_n    = 1'b0;
          nbyte_n   = '0;
          retries_n = '0;
        end
      end
      STA: begin
        if (tick) begin
          if (q == 2'(STA_Q - 1)) begin
            state_n = BIT;
            q_n     = Q0;
            bit_n   = 3'd7;
          end else begin
            q_n = q + 2'd1;
          end
        end
      end
      BIT: begin
        if (tick) begin
          if (q == 2'(BIT_Q - 1)) begin
            q_n = Q0;
            if (bit_idx == 3'd0) state_n = ACK;
            else                 bit_n   = bit_idx - 3'd1;
          end else begin
            q_n = q + 2'd1;
          end
        end
      end
      ACK: begin
        if (tick) begin
          if (q == Q2) nsmp_n = I2C_SDAT;
          if (q == Q3) begin
            q_n = Q0;
            if (!nsmp && (byte_idx != LAST_BYTE)) begin
              state_n = BIT;
              byte_n  = byte_idx + BW'(1);
              bit_n   = 3'd7;
            end else begin
              state_n = STP;
              if (nsmp) begin
                failed_n = 1'b1;
                nbyte_n  = byte_idx;
              end
            end
          end else begin
            q_n = q + 2'd1;
          end
        end
      end
      STP: begin
        if (tick) begin
          if (q == 2'(STP_Q - 1)) begin
            q_n = Q0;
            // A failed attempt with retries left replays the captured frame from byte 0.
            if (failed && (retries_q < RETRY_MAX)) begin
              state_n   = STA;
              retries_n = retries_q + RW'(1);
              failed_n  = 1'b0;
              byte_n    = '0;
              bit_n     = 3'd7;
            end else begin
              state_n = FIN;
              nack_n  = failed;
            end
          end else begin
            q_n = q + 2'd1;
          end
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase

    shifted  = data_n << {byte_n, 3'b000};
    cur_byte = shifted[DW-1 -: 8];
    {scl_n, sda_low_n} = bus_drive(state_n, q_n, cur_byte[bit_n]);
  end

  assign BUSY      = (state != IDLE);
  assign DONE      = (state == FIN);
  assign NACK      = nack_q;
  assign NACK_BYTE = nbyte_q;
  assign RETRIES   = retries_q;
  assign I2C_SCLK  = scl_q;
  assign I2C_SDAT  = sda_low_q ? 1'b0 : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_writer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_i2c_master_writer: directed bench with bus monitor and slave |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_i2c_master_writer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start1, start2;
  logic [23:0] data1;
  logic [7:0]  data2;
  logic        busy1, done1, nack1, scl1;
  logic [2:0]  nbyte1, ret1;
  logic        busy2, done2, nack2, scl2;
  logic [0:0]  nbyte2, ret2;
  wire         sda1, sda2;
  logic        slave_low = 1'b0;

  pullup (sda1);
  pullup (sda2);
  assign sda1 = slave_low ? 1'b0 : 1'bz;

  i2c_master_writer #(.NUM_BYTES(3), .CLK_DIV(4), .MAX_RETRY(2)) dut1 (
    .CLK(clk), .RESET(rst), .START(start1), .DATA(data1), .BUSY(busy1), .DONE(done1),
    .NACK(nack1), .NACK_BYTE(nbyte1), .RETRIES(ret1), .I2C_SCLK(scl1), .I2C_SDAT(sda1)
  );

  i2c_master_writer #(.NUM_BYTES(1), .CLK_DIV(2), .MAX_RETRY(0)) dut2 (
    .CLK(clk), .RESET(rst), .START(start2), .DATA(data2), .BUSY(busy2), .DONE(done2),
    .NACK(nack2), .NACK_BYTE(nbyte2), .RETRIES(ret2), .I2C_SCLK(scl2), .I2C_SDAT(sda2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Bus monitor and slave: decodes START/STOP/bytes, answers the ACK slot by mode.
  int         mode     = 0;
  int         sta_base = 0;
  int         nsta = 0, nsto = 0, ndone = 0;
  logic [7:0] got_q[$];
  int         bitcnt = 0, byteno = 0;
  logic       acking = 1'b0;
  logic [7:0] shr = 8'h00;
  logic       scl_p = 1'b1, sda_p = 1'b1;

  function automatic logic want_nack(input int m, input int bn, input int attempt);
    return (m == 1 && bn == 1) || (m == 2 && bn == 0 && attempt == 1);
  endfunction

  always @(negedge clk) begin
    if (scl_p && scl1 && sda_p && !sda1) begin
      nsta++;
      bitcnt = 0;
      byteno = 0;
      acking = 1'b0;
    end else if (scl_p && scl1 && !sda_p && sda1) begin
      nsto++;
    end else if (!scl_p && scl1) begin
      if (!acking && bitcnt < 8) begin
        shr = {shr[6:0], sda1};
        bitcnt++;
        if (bitcnt == 8) got_q.push_back(shr);
      end
    end else if (scl_p && !scl1) begin
      if (acking) begin
        slave_low = 1'b0;
        acking    = 1'b0;
        bitcnt    = 0;
        byteno++;
      end else if (bitcnt == 8) begin
        acking    = 1'b1;
        slave_low = !want_nack(mode, byteno, nsta - sta_base);
      end
    end
    if (done1) ndone++;
    scl_p = scl1;
    sda_p = sda1;
  end

  // Latency counts clock edges from the accept edge (inclusive) to the DONE cycle.
  task automatic run_txn(input logic [23:0] d, input int poke_start, input int poke_rst,
                         output int lat);
    int n;
    lat = 0;
    @(negedge clk);
    data1  = d;
    start1 = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start1 = 1'b0;
    data1  = 24'h5A5A5A;
    while (n < 1500) begin
      if (done1) begin
        lat = n;
        break;
      end
      if (n == poke_start) begin
        start1 = 1'b1;
        data1  = 24'hFFFFFF;
      end else begin
        start1 = 1'b0;
      end
      rst = (n == poke_rst);
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == poke_rst + 1) begin
        chk_eq("rst_scl", scl1, 1'b1);
        chk_eq("rst_sda", sda1, 1'b1);
        chk_eq("rst_busy", busy1, 1'b0);
        chk_eq("rst_done", done1, 1'b0);
      end
    end
    start1 = 1'b0;
    rst    = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input int base, input int cnt,
                           input logic [23:0] exp);
    chk_eq({tag, "_nbytes"}, got_q.size() - base, cnt);
    chk_eq({tag, "_b0"}, got_q[got_q.size() - 3], exp[23:16]);
    chk_eq({tag, "_b1"}, got_q[got_q.size() - 2], exp[15:8]);
    chk_eq({tag, "_b2"}, got_q[got_q.size() - 1], exp[7:0]);
  endtask

  initial begin
    int lat, sb, so, db, gb, n;
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; data1 = '0; data2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_eq("reset_busy", busy1, 1'b0);
    chk_eq("reset_done", done1, 1'b0);
    chk_eq("reset_nack", nack1, 1'b0);
    chk_eq("reset_nbyte", nbyte1, 3'd0);
    chk_eq("reset_retries", ret1, 3'd0);
    chk_eq("reset_scl", scl1, 1'b1);
    chk_eq("reset_sda", sda1, 1'b1);
    chk_eq("reset_scl2", scl2, 1'b1);

    // 1: clean three-byte write
    mode = 0; sta_base = nsta; sb = nsta; so = nsto; db = ndone; gb = got_q.size();
    run_txn(24'h341EA5, -1, -1, lat);
    repeat (20) @(negedge clk);
    chk_eq("ok_latency", lat, 453);
    chk_frame("ok", gb, 3, 24'h341EA5);
    chk_eq("ok_nack", nack1, 1'b0);
    chk_eq("ok_retries", ret1, 3'd0);
    chk_eq("ok_starts", nsta - sb, 1);
    chk_eq("ok_stops", nsto - so, 1);
    chk_eq("ok_dones", ndone - db, 1);
    chk_eq("ok_busy_after", busy1, 1'b0);

    // 2: byte 1 NACKed on every attempt
    mode = 1; sta_base = nsta; sb = nsta; so = nsto; db = ndone; gb = got_q.size();
    run_txn(24'h341EA5, -1, -1, lat);
    repeat (20) @(negedge clk);
    chk_eq("nk_latency", lat, 925);
    chk_eq("nk_starts", nsta - sb, 3);
    chk_eq("nk_stops", nsto - so, 3);
    chk_eq("nk_dones", ndone - db, 1);
    chk_eq("nk_nack", nack1, 1'b1);
    chk_eq("nk_nbyte", nbyte1, 3'd1);
    chk_eq("nk_retries", ret1, 3'd2);
    chk_eq("nk_nbytes", got_q.size() - gb, 6);

    // 3: byte 0 NACKed on the first attempt only
    mode = 2; sta_base = nsta; sb = nsta; db = ndone; gb = got_q.size();
    run_txn(24'h341EA5, -1, -1, lat);
    repeat (20) @(negedge clk);
    chk_eq("rt_latency", lat, 617);
    chk_frame("rt", gb, 4, 24'h341EA5);
    chk_eq("rt_first", got_q[gb], 8'h34);
    chk_eq("rt_starts", nsta - sb, 2);
    chk_eq("rt_nack", nack1, 1'b0);
    chk_eq("rt_retries", ret1, 3'd1);
    chk_eq("rt_dones", ndone - db, 1);

    // 4: START while busy is ignored
    mode = 0; sta_base = nsta; db = ndone; gb = got_q.size();
    run_txn(24'h341EA5, 50, -1, lat);
    repeat (20) @(negedge clk);
    chk_eq("ign_latency", lat, 453);
    chk_frame("ign", gb, 3, 24'h341EA5);
    chk_eq("ign_dones", ndone - db, 1);

    // 5: reset mid-transfer, then a fresh frame
    sta_base = nsta; db = ndone;
    run_txn(24'h341EA5, -1, 100, lat);
    chk_eq("abort_latency", lat, 0);
    chk_eq("abort_dones", ndone - db, 0);
    sta_base = nsta; sb = nsta; db = ndone; gb = got_q.size();
    run_txn(24'h341EA5, -1, -1, lat);
    repeat (20) @(negedge clk);
    chk_eq("post_latency", lat, 453);
    chk_frame("post", gb, 3, 24'h341EA5);
    chk_eq("post_starts", nsta - sb, 1);
    chk_eq("post_dones", ndone - db, 1);

    // 6: single byte, fastest divider, no retry, no slave present
    @(negedge clk);
    data2  = 8'hA5;
    start2 = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 0;
    while (n < 300) begin
      if (done2) begin
        lat = n;
        break;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk_eq("one_latency", lat, 83);
    chk_eq("one_nack", nack2, 1'b1);
    chk_eq("one_nbyte", nbyte2, 1'b0);
    chk_eq("one_retries", ret2, 1'b0);
    repeat (5) @(negedge clk);
    chk_eq("one_nack_sticky", nack2, 1'b1);
    chk_eq("one_busy_after", busy2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
